// File: rtl/nes_joy_pkg.sv
// Shared constants and types for the joystick register block.
package nes_joy_pkg;

    localparam logic [15:0] JOY0_ADDR = 16'h4016;
    localparam logic [15:0] JOY1_ADDR = 16'h4017;
    localparam logic [15:0] RELEASED  = 16'hFFFF;

    localparam int          SHIFT_W       = 8;
    localparam logic [3:0]  SHIFT_CNT_MAX = 4'd8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        CAP  = 2'd2
    } fetch_state_e;

    // Converts a stored snapshot to the CPU view where 1 means pressed.
    function automatic logic [15:0] pad_view(input logic [15:0] raw, input bit invert);
        logic [15:0] view_v;
        if (invert) begin
            view_v = ~raw;
        end else begin
            view_v = raw;
        end
        return view_v;
    endfunction

endpackage

// File: rtl/nes_joy_shift.sv
// One NES controller serial shift register: parallel reload, shift-left with
// fill 1, and a read counter that saturates once all buttons are consumed.
module nes_joy_shift
    import nes_joy_pkg::*;
(
    input  logic               sysclk,
    input  logic               reset,
    input  logic               load,
    input  logic               shift,
    input  logic [SHIFT_W-1:0] load_val,
    output logic               msb
);

    logic [SHIFT_W-1:0] sh_r;
    logic [3:0]         cnt_r;

    // Reload takes priority over a shift in the same cycle.
    always_ff @(posedge sysclk or posedge reset) begin
        if (reset) begin
            sh_r  <= 8'h00;
            cnt_r <= 4'd0;
        end else if (load) begin
            sh_r  <= load_val;
            cnt_r <= 4'd0;
        end else if (shift) begin
            sh_r <= {sh_r[SHIFT_W-2:0], 1'b1};
            if (cnt_r != SHIFT_CNT_MAX) begin
                cnt_r <= cnt_r + 4'd1;
            end
        end
    end

    assign msb = sh_r[SHIFT_W-1];

endmodule

// File: rtl/nes_joy_regs.sv
// CPU-side joystick registers: drains snapshots from the PHY FIFO and serves
// $4016/$4017 with NES strobe/shift semantics, plus a stale-snapshot watchdog.
module nes_joy_regs
    import nes_joy_pkg::*;
#(
    parameter bit         INVERT_IN = 1'b1,
    parameter int         STALE_CYC = 65535,
    parameter logic [7:0] OPEN_BUS  = 8'h40
) (
    input  logic        sysclk,
    input  logic        reset,
    input  logic        cpu_clock,
    input  logic [15:0] cpu_addr,
    input  logic        cpu_rw,
    input  logic [7:0]  cpu_din,
    output logic [7:0]  cpu_dout,
    output logic        cpu_dsel,
    input  logic        fifo_empty,
    output logic        fifo_rdreq,
    input  logic [15:0] fifo_q,
    output logic        joy_stale,
    output logic        strobe
);

    localparam int                  STALE_W   = $clog2(STALE_CYC + 1);
    localparam logic [STALE_W-1:0]  STALE_MAX = STALE_W'(STALE_CYC);
    localparam logic [STALE_W-1:0]  STALE_ONE = STALE_W'(1);

    fetch_state_e        state_r;
    logic                fifo_rdreq_r;
    logic [15:0]         latest_r;
    logic [STALE_W-1:0]  stale_cnt_r;
    logic                joy_stale_r;
    logic                strobe_r;

    logic                sel_joy0_s;
    logic                sel_joy1_s;
    logic                wr_joy0_s;
    logic                load_s;
    logic                shift0_s;
    logic                shift1_s;
    logic [15:0]         vis_s;
    logic                sh0_msb_s;
    logic                sh1_msb_s;
    logic                pad0_bit_s;
    logic                pad1_bit_s;
    logic                unused_din_s;

    assign sel_joy0_s   = (cpu_addr == JOY0_ADDR);
    assign sel_joy1_s   = (cpu_addr == JOY1_ADDR);
    assign wr_joy0_s    = cpu_clock & ~cpu_rw & sel_joy0_s;
    assign unused_din_s = ^cpu_din[7:1];

    // Fetch FSM plus stale watchdog; a capture overrides a same-cycle timeout.
    always_ff @(posedge sysclk or posedge reset) begin
        if (reset) begin
            state_r      <= IDLE;
            fifo_rdreq_r <= 1'b0;
            latest_r     <= RELEASED;
            stale_cnt_r  <= '0;
            joy_stale_r  <= 1'b1;
        end else begin
            fifo_rdreq_r <= 1'b0;
            if (cpu_clock) begin
                if (stale_cnt_r != STALE_MAX) begin
                    stale_cnt_r <= stale_cnt_r + STALE_ONE;
                end
                if (stale_cnt_r >= STALE_MAX - STALE_ONE) begin
                    latest_r    <= RELEASED;
                    joy_stale_r <= 1'b1;
                end
            end
            case (state_r)
                IDLE: begin
                    if (!fifo_empty) begin
                        state_r      <= REQ;
                        fifo_rdreq_r <= 1'b1;
                    end
                end
                REQ: begin
                    state_r <= CAP;
                end
                CAP: begin
                    latest_r    <= fifo_q;
                    stale_cnt_r <= '0;
                    joy_stale_r <= 1'b0;
                    state_r     <= IDLE;
                end
                default: begin
                    state_r <= IDLE;
                end
            endcase
        end
    end

    // $4016 bit 0 latches the controller strobe.
    always_ff @(posedge sysclk or posedge reset) begin
        if (reset) begin
            strobe_r <= 1'b0;
        end else if (wr_joy0_s) begin
            strobe_r <= cpu_din[0];
        end
    end

    assign vis_s = pad_view(latest_r, INVERT_IN);

    // Reload while strobe is high, on the write raising it, and on the final 1->0 write.
    assign load_s   = cpu_clock & (strobe_r | (wr_joy0_s & cpu_din[0]));
    assign shift0_s = cpu_clock & cpu_rw & sel_joy0_s;
    assign shift1_s = cpu_clock & cpu_rw & sel_joy1_s;

    nes_joy_shift u_pad0 (
        .sysclk   (sysclk),
        .reset    (reset),
        .load     (load_s),
        .shift    (shift0_s),
        .load_val (vis_s[7:0]),
        .msb      (sh0_msb_s)
    );

    nes_joy_shift u_pad1 (
        .sysclk   (sysclk),
        .reset    (reset),
        .load     (load_s),
        .shift    (shift1_s),
        .load_val (vis_s[15:8]),
        .msb      (sh1_msb_s)
    );

    // With strobe held the pads are transparent, so A tracks the newest snapshot.
    assign pad0_bit_s = strobe_r ? vis_s[7]  : sh0_msb_s;
    assign pad1_bit_s = strobe_r ? vis_s[15] : sh1_msb_s;

    // Read mux for the two controller ports.
    always_comb begin
        cpu_dout = 8'h00;
        if (cpu_rw && sel_joy0_s) begin
            cpu_dout = {OPEN_BUS[7:1], pad0_bit_s};
        end else if (cpu_rw && sel_joy1_s) begin
            cpu_dout = {OPEN_BUS[7:1], pad1_bit_s};
        end else begin
            cpu_dout = 8'h00;
        end
    end

    assign cpu_dsel   = cpu_rw & (sel_joy0_s | sel_joy1_s);
    assign fifo_rdreq = fifo_rdreq_r;
    assign joy_stale  = joy_stale_r;
    assign strobe     = strobe_r;

endmodule

// File: tb/tb_nes_joy_regs.sv
// Directed plus randomized bench for nes_joy_regs against a button-level model.
module tb_nes_joy_regs;

    localparam int STALE = 16;

    logic        sysclk;
    logic        reset;
    logic        cpu_clock;
    logic [15:0] cpu_addr;
    logic        cpu_rw;
    logic [7:0]  cpu_din;
    logic [7:0]  cpu_dout;
    logic        cpu_dsel;
    logic        fifo_empty;
    logic        fifo_rdreq;
    logic [15:0] fifo_data;
    logic        joy_stale;
    logic        strobe;

    int checks = 0;
    int errors = 0;
    int pulses = 0;
    logic [15:0] fq[$];

    // Reference model: snapshot, strobe, per-pad latched buttons and read index.
    logic [15:0] m_latest;
    logic        m_strobe;
    logic        m_stale;
    int          m_age;
    logic [7:0]  m_pad [2];
    int          m_idx [2];

    nes_joy_regs #(
        .INVERT_IN (1'b1),
        .STALE_CYC (STALE),
        .OPEN_BUS  (8'h40)
    ) dut (
        .sysclk     (sysclk),
        .reset      (reset),
        .cpu_clock  (cpu_clock),
        .cpu_addr   (cpu_addr),
        .cpu_rw     (cpu_rw),
        .cpu_din    (cpu_din),
        .cpu_dout   (cpu_dout),
        .cpu_dsel   (cpu_dsel),
        .fifo_empty (fifo_empty),
        .fifo_rdreq (fifo_rdreq),
        .fifo_q     (fifo_data),
        .joy_stale  (joy_stale),
        .strobe     (strobe)
    );

    initial sysclk = 1'b0;
    always #5 sysclk = ~sysclk;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic m_reset();
        m_latest = 16'hFFFF;
        m_strobe = 1'b0;
        m_stale  = 1'b1;
        m_age    = 0;
        m_pad[0] = 8'h00;
        m_pad[1] = 8'h00;
        m_idx[0] = 0;
        m_idx[1] = 0;
    endtask

    // One sysclk; the FIFO model pops on the edge where it sees a request.
    task automatic step();
        logic pop;
        pop = fifo_rdreq;
        if (pop) check("rdreq_nonempty", 16'(fifo_empty), 16'd0);
        @(posedge sysclk);
        #1;
        if (pop) begin
            pulses++;
            if (fq.size() > 0) fifo_data = fq.pop_front();
            fifo_empty = (fq.size() == 0);
        end
    endtask

    task automatic fetch(input logic [15:0] word);
        fq.push_back(word);
        fifo_empty = 1'b0;
        pulses = 0;
        repeat (6) step();
        check("fetch_pulses", 16'(pulses), 16'd1);
        check("fetch_drained", 16'(fifo_empty), 16'd1);
        m_latest = word;
        m_age    = 0;
        m_stale  = 1'b0;
        check("fetch_stale", 16'(joy_stale), 16'd0);
    endtask

    task automatic cpu_cycle(input logic [15:0] addr, input logic rw, input logic [7:0] din,
                             input string tag);
        logic [15:0] vis;
        logic        exp_bit;
        logic        exp_sel;
        logic [7:0]  exp_dout;
        logic        wr0;
        int          p;
        vis = ~m_latest;
        cpu_addr  = addr;
        cpu_rw    = rw;
        cpu_din   = din;
        cpu_clock = 1'b1;
        exp_sel = rw && (addr == 16'h4016 || addr == 16'h4017);
        p = (addr == 16'h4017) ? 1 : 0;
        if (m_strobe) exp_bit = vis[7 + 8 * p];
        else if (m_idx[p] < 8) exp_bit = m_pad[p][7 - m_idx[p]];
        else exp_bit = 1'b1;
        exp_dout = exp_sel ? (8'h40 | {7'd0, exp_bit}) : 8'h00;
        @(negedge sysclk);
        check({tag, "_dout"}, 16'(cpu_dout), 16'(exp_dout));
        check({tag, "_dsel"}, 16'(cpu_dsel), 16'(exp_sel));
        wr0 = !rw && addr == 16'h4016;
        if (m_strobe || (wr0 && din[0])) begin
            m_pad[0] = vis[7:0];
            m_pad[1] = vis[15:8];
            m_idx[0] = 0;
            m_idx[1] = 0;
        end else if (rw && addr == 16'h4016) begin
            if (m_idx[0] < 8) m_idx[0]++;
        end else if (rw && addr == 16'h4017) begin
            if (m_idx[1] < 8) m_idx[1]++;
        end
        if (wr0) m_strobe = din[0];
        m_age++;
        if (m_age >= STALE) begin
            m_latest = 16'hFFFF;
            m_stale  = 1'b1;
        end
        step();
        cpu_clock = 1'b0;
        cpu_addr  = 16'h0000;
        cpu_rw    = 1'b1;
        check({tag, "_stale"}, 16'(joy_stale), 16'(m_stale));
        check({tag, "_strobe"}, 16'(strobe), 16'(m_strobe));
    endtask

    initial begin
        logic seen;
        logic [15:0] w;
        int op;
        reset      = 1'b1;
        cpu_clock  = 1'b0;
        cpu_addr   = 16'h0000;
        cpu_rw     = 1'b1;
        cpu_din    = 8'h00;
        fifo_empty = 1'b1;
        fifo_data  = 16'h0000;
        m_reset();
        repeat (2) @(posedge sysclk);
        #1;
        check("rst_rdreq", 16'(fifo_rdreq), 16'd0);
        check("rst_strobe", 16'(strobe), 16'd0);
        check("rst_stale", 16'(joy_stale), 16'd1);
        reset = 1'b0;
        step();
        cpu_cycle(16'h4016, 1'b1, 8'h00, "rst_read");

        // Fetch and serial readout of both pads.
        fetch(16'h7EFE);
        cpu_cycle(16'h4016, 1'b0, 8'h01, "wr_s1");
        cpu_cycle(16'h4016, 1'b0, 8'h00, "wr_s0");
        for (int i = 0; i < 10; i++) cpu_cycle(16'h4016, 1'b1, 8'h00, "pad0_rd");
        cpu_cycle(16'h4016, 1'b0, 8'h01, "wr_s1b");
        cpu_cycle(16'h4016, 1'b0, 8'h00, "wr_s0b");
        for (int i = 0; i < 8; i++) cpu_cycle(16'h4017, 1'b1, 8'h00, "pad1_rd");
        cpu_cycle(16'h4016, 1'b1, 8'h00, "pad0_indep");
        cpu_cycle(16'h4017, 1'b0, 8'h00, "wr_4017");

        // Strobe held high tracks a new snapshot.
        fetch(16'h7E7F);
        cpu_cycle(16'h4016, 1'b0, 8'h01, "hold_s1");
        for (int i = 0; i < 3; i++) cpu_cycle(16'h4016, 1'b1, 8'h00, "hold_rd");
        fetch(16'hFFFF);
        cpu_cycle(16'h4016, 1'b1, 8'h00, "hold_new");
        cpu_cycle(16'h4016, 1'b0, 8'h00, "hold_s0");

        // Stale watchdog boundary.
        fetch(16'h0F0F);
        for (int i = 0; i < STALE - 1; i++) cpu_cycle(16'h0000, 1'b1, 8'h00, "idle");
        check("stale_at_15", 16'(joy_stale), 16'd0);
        cpu_cycle(16'h0000, 1'b1, 8'h00, "idle16");
        check("stale_at_16", 16'(joy_stale), 16'd1);
        cpu_cycle(16'h4016, 1'b0, 8'h01, "st_s1");
        cpu_cycle(16'h4016, 1'b0, 8'h00, "st_s0");
        cpu_cycle(16'h4016, 1'b1, 8'h00, "st_rd");
        fetch(16'h1234);

        // Reset in the REQ cycle discards the requested word.
        cpu_cycle(16'h4016, 1'b0, 8'h01, "pre_rst_s1");
        fq.push_back(16'h0000);
        fifo_empty = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 6 && !seen; i++) begin
            step();
            seen = fifo_rdreq;
        end
        check("req_seen", 16'(seen), 16'd1);
        reset = 1'b1;
        #1;
        check("mid_rst_rdreq", 16'(fifo_rdreq), 16'd0);
        check("mid_rst_strobe", 16'(strobe), 16'd0);
        fq.delete();
        fifo_empty = 1'b1;
        fifo_data  = 16'h0000;
        m_reset();
        step();
        step();
        reset = 1'b0;
        step();
        check("post_rst_stale", 16'(joy_stale), 16'd1);
        cpu_cycle(16'h4016, 1'b0, 8'h01, "post_s1");
        cpu_cycle(16'h4016, 1'b0, 8'h00, "post_s0");
        cpu_cycle(16'h4016, 1'b1, 8'h00, "post_rd");

        // Randomized mix of fetches and CPU accesses.
        for (int i = 0; i < 120; i++) begin
            op = $urandom_range(6, 0);
            w  = 16'($urandom);
            case (op)
                0: fetch(w);
                1: cpu_cycle(16'h4016, 1'b0, w[7:0], "r_wr0");
                2: cpu_cycle(16'h4016, 1'b1, 8'h00, "r_rd0");
                3: cpu_cycle(16'h4017, 1'b1, 8'h00, "r_rd1");
                4: cpu_cycle(16'h4017, 1'b0, w[7:0], "r_wr1");
                5: cpu_cycle(w, 1'b1, 8'h00, "r_any");
                default: step();
            endcase
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
